// File: rtl/reg_file.sv
// RV64IM integer register file: x0..x31 (64-bit), two combinational read ports, one clocked write port.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module reg_file (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  reg1,
  input  logic [4:0]  reg2,
  input  logic [4:0]  reg_write,
  input  logic [63:0] reg_write_data,
  input  logic        reg_write_enable,
  output logic [63:0] reg1_data,
  output logic [63:0] reg2_data
);

  localparam int XLEN  = 64;
  localparam int NREGS = 32;

  // x0 is hardwired to zero, so storage starts at index 1.
  logic [XLEN-1:0] regs [1:NREGS-1];
  logic            write_hit;

  assign write_hit = reg_write_enable && (reg_write != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these are discrete flops, not a RAM macro, so clearing every entry
      // on reset is intended; an SRAM-based file could not be reset this way.
      for (int i = 1; i < NREGS; i++) begin
        // NOTE: non-blocking assignment keeps every flop update on the clock edge
        // race-free with respect to the combinational readers.
        regs[i] <= '0;
      end
    end else if (write_hit) begin
      regs[reg_write] <= reg_write_data;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns the outputs and no latch is inferred.
    reg1_data = '0;
    reg2_data = '0;
    if (reg1 != 5'd0) reg1_data = regs[reg1];
    if (reg2 != 5'd0) reg2_data = regs[reg2];
`ifdef REGFILE_BYPASS_EN
    // Forwarding is suppressed under reset so the ports read zero while it is held.
    if (rst_n && write_hit && (reg1 == reg_write)) reg1_data = reg_write_data;
    if (rst_n && write_hit && (reg2 == reg_write)) reg2_data = reg_write_data;
`endif
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table, multi-cycle corner sequences,
// and randomized traffic against an array-based reference model.
module tb_reg_file;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [4:0]  reg1;
  logic [4:0]  reg2;
  logic [4:0]  reg_write;
  logic [63:0] reg_write_data;
  logic        reg_write_enable;
  logic [63:0] reg1_data;
  logic [63:0] reg2_data;

  int tests;
  int fails;

  logic [63:0] model [32];

  typedef struct {
    logic        we;
    logic [4:0]  wr;
    logic [63:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [63:0] e1;
    logic [63:0] e2;
  } vec_t;

  vec_t vecs [7];

  reg_file dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .reg1             (reg1),
    .reg2             (reg2),
    .reg_write        (reg_write),
    .reg_write_data   (reg_write_data),
    .reg_write_enable (reg_write_enable),
    .reg1_data        (reg1_data),
    .reg2_data        (reg2_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wr, input logic [63:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    reg_write_enable = we;
    reg_write        = wr;
    reg_write_data   = wd;
    reg1             = r1;
    reg2             = r2;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected read value from the architectural model, including same-cycle forwarding when enabled.
  function automatic logic [63:0] exp_read(input logic [4:0] r, input logic we,
                                           input logic [4:0] wr, input logic [63:0] wd);
    if (r == 5'd0) return 64'd0;
    if (BYPASS && we && wr != 5'd0 && r == wr) return wd;
    return model[r];
  endfunction

  initial begin
    logic        we;
    logic [4:0]  wr, r1, r2;
    logic [63:0] wd;

    tests = 0;
    fails = 0;
    rst_n = 1'b1;
    reg_write_enable = 1'b0;
    reg_write = '0;
    reg_write_data = '0;
    reg1 = '0;
    reg2 = '0;

    vecs[0] = '{1'b1, 5'd1,  64'd5,                  5'd1,  5'd0, 64'd5,                  64'd0};
    vecs[1] = '{1'b1, 5'd2,  64'd10,                 5'd1,  5'd2, 64'd5,                  64'd10};
    vecs[2] = '{1'b0, 5'd3,  64'hFFFF_FFFF_FFFF_FFFF, 5'd1,  5'd2, 64'd5,                  64'd10};
    vecs[3] = '{1'b0, 5'd3,  64'hFFFF_FFFF_FFFF_FFFF, 5'd3,  5'd3, 64'd0,                  64'd0};
    vecs[4] = '{1'b1, 5'd0,  64'hDEAD_BEEF_CAFE_F00D, 5'd0,  5'd0, 64'd0,                  64'd0};
    vecs[5] = '{1'b1, 5'd31, 64'h8000_0000_0000_0001, 5'd31, 5'd1, 64'h8000_0000_0000_0001, 64'd5};
    vecs[6] = '{1'b1, 5'd4,  64'd7,                  5'd4,  5'd4, 64'd7,                  64'd7};

    // Power-on reset, then every index must read zero on both ports.
    #2 rst_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i < 32; i++) begin
      drive(1'b0, 5'd0, 64'd0, i[4:0], 5'(32 - i));
      check($sformatf("reset_r1_x%0d", i), reg1_data, 64'd0);
      check($sformatf("reset_r2_x%0d", 32 - i), reg2_data, 64'd0);
    end
    drive(1'b0, 5'd0, 64'd0, 5'd0, 5'd0);
    check("reset_x0_r1", reg1_data, 64'd0);
    check("reset_x0_r2", reg2_data, 64'd0);

    // Directed vectors: apply, capture on one edge, compare post-edge reads.
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].we, vecs[i].wr, vecs[i].wd, vecs[i].r1, vecs[i].r2);
      tick();
      check($sformatf("vec%0d_r1", i), reg1_data, vecs[i].e1);
      check($sformatf("vec%0d_r2", i), reg2_data, vecs[i].e2);
    end

    // Same-cycle read/write of x4 (holds 7), plus an attempted forward to x0.
    drive(1'b1, 5'd4, 64'd9, 5'd4, 5'd2);
    check("rw_same_pre_r1", reg1_data, BYPASS ? 64'd9 : 64'd7);
    check("rw_same_pre_r2", reg2_data, 64'd10);
    tick();
    check("rw_same_post_r1", reg1_data, 64'd9);
    drive(1'b1, 5'd0, 64'h1234_5678_9ABC_DEF0, 5'd0, 5'd4);
    check("fwd_x0_r1", reg1_data, 64'd0);
    check("fwd_x0_r2", reg2_data, 64'd9);
    tick();
    check("fwd_x0_post", reg1_data, 64'd0);

    // Unknown write data with the enable low must not disturb state.
    drive(1'b0, 5'd5, 64'hx, 5'd5, 5'd4);
    tick();
    check("xdata_x5", reg1_data, 64'd0);
    check("xdata_x4", reg2_data, 64'd9);

    // Async reset between edges with a write pending during reset.
    drive(1'b1, 5'd1, 64'd77, 5'd1, 5'd2);
    check("prereset_x2", reg2_data, 64'd10);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_r1", reg1_data, 64'd0);
    check("async_rst_r2", reg2_data, 64'd0);
    tick();
    check("rst_write_lost_r1", reg1_data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    reg_write_enable = 1'b0;
    #1;
    check("post_rst_x1", reg1_data, 64'd0);
    check("post_rst_x2", reg2_data, 64'd0);
    drive(1'b1, 5'd1, 64'd123, 5'd1, 5'd2);
    check("first_write_pre", reg1_data, BYPASS ? 64'd123 : 64'd0);
    tick();
    check("first_write_post", reg1_data, 64'd123);
    check("first_write_x2", reg2_data, 64'd0);

    // Randomized traffic against the model, starting from a fresh reset.
    @(negedge clk);
    reg_write_enable = 1'b0;
    #2 rst_n = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 64'd0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 400; n++) begin
      we = ($urandom_range(0, 3) != 0);
      wr = 5'($urandom_range(0, 31));
      wd = {$urandom, $urandom};
      r1 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      drive(we, wr, wd, r1, r2);
      check("rand_pre_r1", reg1_data, exp_read(r1, we, wr, wd));
      check("rand_pre_r2", reg2_data, exp_read(r2, we, wr, wd));
      tick();
      if (we && wr != 5'd0) model[wr] = wd;
      check("rand_post_r1", reg1_data, exp_read(r1, we, wr, wd));
      check("rand_post_r2", reg2_data, exp_read(r2, we, wr, wd));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
